sha2_multi_core: RTL and testbench



---
 rtl/sha2_multi_pkg.sv | 108 ++++++++++
 rtl/sha2_round_unroll.sv | 23 ++
 rtl/sha2_multi_core.sv | 240 ++++++++++++++++++++++++
 tb/tb_sha2_multi_core.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_multi_pkg.sv
// Shared constants, types and round functions for the multi-round SHA-2 engine.
package sha2_multi_pkg;

    localparam int unsigned WordW       = 32;
    localparam int unsigned DigestW     = 8 * WordW;
    localparam int unsigned RoundW      = 6;
    localparam int unsigned SchedRounds = 48;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCompress,
        StUpdate
    } sha2_state_e;

    // Working variables; a sits in the MSBs, matching the H0-first digest layout.
    typedef struct packed {
        logic [WordW-1:0] a;
        logic [WordW-1:0] b;
        logic [WordW-1:0] c;
        logic [WordW-1:0] d;
        logic [WordW-1:0] e;
        logic [WordW-1:0] f;
        logic [WordW-1:0] g;
        logic [WordW-1:0] h;
    } sha2_vars_t;

    localparam logic [DigestW-1:0] InitHash256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [DigestW-1:0] InitHash224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam logic [WordW-1:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [WordW-1:0] rotr(input logic [WordW-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WordW - n));
    endfunction

    function automatic logic [WordW-1:0] shiftr(input logic [WordW-1:0] x, input int unsigned n);
        return x >> n;
    endfunction

    function automatic logic [WordW-1:0] small_sigma0(input logic [WordW-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ shiftr(x, 3);
    endfunction

    function automatic logic [WordW-1:0] small_sigma1(input logic [WordW-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ shiftr(x, 10);
    endfunction

    function automatic logic [WordW-1:0] big_sigma0(input logic [WordW-1:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WordW-1:0] big_sigma1(input logic [WordW-1:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic sha2_vars_t round_step(input sha2_vars_t v, input logic [WordW-1:0] w,
                                              input logic [WordW-1:0] k);
        logic [WordW-1:0] ch;
        logic [WordW-1:0] maj;
        logic [WordW-1:0] t1;
        logic [WordW-1:0] t2;
        sha2_vars_t       r;
        ch  = (v.e & v.f) ^ (~v.e & v.g);
        maj = (v.a & v.b) ^ (v.a & v.c) ^ (v.b & v.c);
        t1  = v.h + big_sigma1(v.e) + ch + k + w;
        t2  = big_sigma0(v.a) + maj;
        r.a = t1 + t2;
        r.b = v.a;
        r.c = v.b;
        r.d = v.c;
        r.e = v.d + t1;
        r.f = v.e;
        r.g = v.f;
        r.h = v.g;
        return r;
    endfunction

    // Next schedule word from W[n-16], W[n-15], W[n-7], W[n-2].
    function automatic logic [WordW-1:0] calc_w(input logic [WordW-1:0] w_m16,
                                                input logic [WordW-1:0] w_m15,
                                                input logic [WordW-1:0] w_m7,
                                                input logic [WordW-1:0] w_m2);
        return small_sigma1(w_m2) + w_m7 + small_sigma0(w_m15) + w_m16;
    endfunction

endpackage

// File: rtl/sha2_round_unroll.sv
// Combinational chain of RoundsPerCycle SHA-2 compression rounds.
module sha2_round_unroll
    import sha2_multi_pkg::*;
#(
    parameter int unsigned RoundsPerCycle = 1
) (
    input  logic [DigestW-1:0]              vars_i,
    input  logic [WordW*RoundsPerCycle-1:0] w_i,
    input  logic [WordW*RoundsPerCycle-1:0] k_i,
    output logic [DigestW-1:0]              vars_o
);

    sha2_vars_t chain [RoundsPerCycle+1];

    assign chain[0] = sha2_vars_t'(vars_i);

    for (genvar r = 0; r < RoundsPerCycle; r++) begin : g_round
        assign chain[r+1] = round_step(chain[r], w_i[WordW*r +: WordW], k_i[WordW*r +: WordW]);
    end

    assign vars_o = DigestW'(chain[RoundsPerCycle]);

endmodule

// File: rtl/sha2_multi_core.sv
// SHA-256/224 compression engine, RoundsPerCycle rounds per clock.
// Optional secret wipe port pair enabled by defining SHA2_MULTI_WIPE_EN.
module sha2_multi_core
    import sha2_multi_pkg::*;
#(
    parameter int unsigned RoundsPerCycle = 1,
    parameter int unsigned MsgWidth       = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sha_en_i,
    input  logic                mode_i,
    input  logic                hash_start_i,
    input  logic                msg_valid_i,
    input  logic [MsgWidth-1:0] msg_data_i,
    input  logic                msg_last_i,
`ifdef SHA2_MULTI_WIPE_EN
    input  logic                wipe_secret_i,
    input  logic [WordW-1:0]    wipe_v_i,
`endif
    output logic                msg_ready_o,
    output logic                busy_o,
    output logic                hash_done_o,
    output logic                err_o,
    output logic [DigestW-1:0]  digest_o
);

    if (!(RoundsPerCycle == 1 || RoundsPerCycle == 2 || RoundsPerCycle == 4)) begin : g_bad_rpc
        $error("sha2_multi_core: RoundsPerCycle must be 1, 2 or 4");
    end
    if (MsgWidth != WordW) begin : g_bad_msg_width
        $error("sha2_multi_core: MsgWidth must be 32");
    end

    sha2_state_e state_q, state_d;

    logic [WordW-1:0]                w_q   [16];
    logic [WordW-1:0]                w_ext [16+RoundsPerCycle];
    logic [WordW*RoundsPerCycle-1:0] w_vec;
    logic [WordW*RoundsPerCycle-1:0] k_vec;
    logic [DigestW-1:0]              work_q;
    logic [DigestW-1:0]              work_rnd;
    logic [DigestW-1:0]              hash_q;
    logic [DigestW-1:0]              hash_sum;
    logic [RoundW-1:0]               rnd_q;
    logic [RoundW-1:0]               rnd_nxt;
    logic [3:0]                      widx_q;
    logic                            last_q;
    logic                            mode_q;
    logic                            done_q;
    logic                            err_q;
    logic                            hs;
    logic                            round_wrap;
    logic                            start_ok;
    logic                            err_d;
    logic                            done_d;

    assign rnd_nxt    = rnd_q + RoundW'(RoundsPerCycle);
    assign round_wrap = (rnd_nxt == '0);
    assign hs         = msg_valid_i && msg_ready_o;

    // State register; a wipe freezes the FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end
`ifdef SHA2_MULTI_WIPE_EN
        else if (wipe_secret_i) begin
            state_q <= state_q;
        end
`endif
        else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a low enable always returns to Idle.
    always_comb begin
        state_d = state_q;
        if (!sha_en_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:     if (hash_start_i) state_d = StLoad;
                StLoad:     if (hs && widx_q == 4'd15) state_d = StCompress;
                StCompress: if (round_wrap) state_d = StUpdate;
                StUpdate:   state_d = last_q ? StIdle : StLoad;
                default:    state_d = StIdle;
            endcase
        end
    end

    // Output and strobe decode.
    always_comb begin
        msg_ready_o = 1'b0;
        start_ok    = 1'b0;
        err_d       = 1'b0;
        done_d      = 1'b0;
        if (sha_en_i) begin
            msg_ready_o = (state_q == StLoad);
            start_ok    = hash_start_i && (state_q == StIdle);
            err_d       = hash_start_i && (state_q != StIdle);
            done_d      = (state_q == StUpdate) && last_q;
        end
`ifdef SHA2_MULTI_WIPE_EN
        if (wipe_secret_i) begin
            msg_ready_o = 1'b0;
            start_ok    = 1'b0;
            err_d       = 1'b0;
            done_d      = 1'b0;
        end
`endif
    end

    assign busy_o      = (state_q != StIdle);
    assign hash_done_o = done_q;
    assign err_o       = err_q;
    assign digest_o    = hash_q;

    // In-place message schedule: extend by RoundsPerCycle words until round 48.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = w_q[i];
        end
        for (int j = 0; j < int'(RoundsPerCycle); j++) begin
            w_ext[16+j] = '0;
        end
        if (rnd_q < RoundW'(SchedRounds)) begin
            for (int j = 0; j < int'(RoundsPerCycle); j++) begin
                w_ext[16+j] = calc_w(w_ext[j], w_ext[j+1], w_ext[j+9], w_ext[j+14]);
            end
        end
    end

    always_comb begin
        for (int r = 0; r < int'(RoundsPerCycle); r++) begin
            w_vec[WordW*r +: WordW] = w_q[r];
            k_vec[WordW*r +: WordW] = K[rnd_q + RoundW'(r)];
        end
    end

    // Feed-forward add; SHA-224 drops H7 on the final block.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            hash_sum[WordW*i +: WordW] = hash_q[WordW*i +: WordW] + work_q[WordW*i +: WordW];
        end
        if (last_q && mode_q) begin
            hash_sum[WordW-1:0] = '0;
        end
    end

    sha2_round_unroll #(
        .RoundsPerCycle(RoundsPerCycle)
    ) u_round_unroll (
        .vars_i(work_q),
        .w_i   (w_vec),
        .k_i   (k_vec),
        .vars_o(work_rnd)
    );

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            work_q <= '0;
            hash_q <= '0;
            rnd_q  <= '0;
            widx_q <= '0;
            last_q <= 1'b0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end
`ifdef SHA2_MULTI_WIPE_EN
        else if (wipe_secret_i) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= w_q[i] ^ wipe_v_i;
            end
            work_q <= work_q ^ {8{wipe_v_i}};
            hash_q <= hash_q ^ {8{wipe_v_i}};
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end
`endif
        else if (!sha_en_i) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            work_q <= '0;
            hash_q <= '0;
            rnd_q  <= '0;
            widx_q <= '0;
            last_q <= 1'b0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        hash_q <= mode_i ? InitHash224 : InitHash256;
                        mode_q <= mode_i;
                        widx_q <= '0;
                        last_q <= 1'b0;
                    end
                end
                StLoad: begin
                    if (hs) begin
                        for (int i = 0; i < 15; i++) begin
                            w_q[i] <= w_q[i+1];
                        end
                        w_q[15] <= msg_data_i;
                        widx_q  <= widx_q + 4'd1;
                        if (widx_q == 4'd15) begin
                            last_q <= msg_last_i;
                            work_q <= hash_q;
                            rnd_q  <= '0;
                        end
                    end
                end
                StCompress: begin
                    work_q <= work_rnd;
                    rnd_q  <= rnd_nxt;
                    for (int i = 0; i < 16; i++) begin
                        w_q[i] <= w_ext[i+int'(RoundsPerCycle)];
                    end
                end
                StUpdate: begin
                    hash_q <= hash_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_multi_core.sv
// Directed bench for sha2_multi_core with one instance per RoundsPerCycle (1, 2, 4).
module tb_sha2_multi_core;

    localparam int NDut = 3;

    localparam logic [255:0] Abc256 =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] Abc224 =
        256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] TwoBlk =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] Iv224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en    [NDut];
    logic         mode  [NDut];
    logic         start [NDut];
    logic         vld   [NDut];
    logic [31:0]  dat   [NDut];
    logic         last  [NDut];
    logic         rdy   [NDut];
    logic         busy  [NDut];
    logic         done  [NDut];
    logic         err   [NDut];
    logic [255:0] dg    [NDut];
`ifdef SHA2_MULTI_WIPE_EN
    logic         wipe  [NDut];
    logic [31:0]  wv    [NDut];
`endif

    typedef struct {
        logic [255:0] dig;
        int           lat;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] msg [48];
    int          checks   = 0;
    int          failures = 0;
    int          cyc_cnt  = 0;
    int          hs_cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    for (genvar g = 0; g < NDut; g++) begin : g_dut
        sha2_multi_core #(
            .RoundsPerCycle(1 << g)
        ) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .sha_en_i     (en[g]),
            .mode_i       (mode[g]),
            .hash_start_i (start[g]),
            .msg_valid_i  (vld[g]),
            .msg_data_i   (dat[g]),
            .msg_last_i   (last[g]),
`ifdef SHA2_MULTI_WIPE_EN
            .wipe_secret_i(wipe[g]),
            .wipe_v_i     (wv[g]),
`endif
            .msg_ready_o  (rdy[g]),
            .busy_o       (busy[g]),
            .hash_done_o  (done[g]),
            .err_o        (err[g]),
            .digest_o     (dg[g])
        );
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [255:0] dig, input int lat);
        exp_t e;
        e.dig = dig;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    // All tasks start and end right after a falling edge.
    task automatic start_msg(input int d, input logic m);
        mode[d]  = m;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic send_word(input int d, input logic [31:0] w, input logic l, input int gap);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        repeat (gap) @(negedge clk);
        vld[d]  = 1'b1;
        dat[d]  = w;
        last[d] = l;
        while (!hs && n < 400) begin
            #1;
            hs = rdy[d];
            if (hs) hs_cyc = cyc_cnt;
            @(negedge clk);
            n++;
        end
        vld[d]  = 1'b0;
        last[d] = 1'b0;
        chk("handshake", 256'(hs), 256'(1));
    endtask

    task automatic send_block(input int d, input int base, input logic fin, input int max_gap,
                              input bit noisy_last);
        logic l;
        int   gap;
        for (int i = 0; i < 16; i++) begin
            l   = (i == 15) ? fin : (noisy_last ? 1'($urandom_range(0, 1)) : 1'b0);
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            send_word(d, msg[base+i], l, gap);
        end
    endtask

    task automatic wait_done(input int d, input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!done[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 256'(done[d]), 256'(1));
        chk({tag, "_sb"}, 256'(exp_q.size() != 0), 256'(1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_latency"}, 256'(cyc_cnt - hs_cyc), 256'(e.lat));
            chk({tag, "_digest"}, dg[d], e.dig);
        end
        @(negedge clk);
        chk({tag, "_pulse"}, 256'(done[d]), 256'(0));
        chk({tag, "_idle"}, 256'(busy[d]), 256'(0));
    endtask

    initial begin
        bit seen_done;

        for (int i = 0; i < 48; i++) msg[i] = '0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        msg[16] = 32'h61626364; msg[17] = 32'h62636465; msg[18] = 32'h63646566;
        msg[19] = 32'h64656667; msg[20] = 32'h65666768; msg[21] = 32'h66676869;
        msg[22] = 32'h6768696a; msg[23] = 32'h68696a6b; msg[24] = 32'h696a6b6c;
        msg[25] = 32'h6a6b6c6d; msg[26] = 32'h6b6c6d6e; msg[27] = 32'h6c6d6e6f;
        msg[28] = 32'h6d6e6f70; msg[29] = 32'h6e6f7071; msg[30] = 32'h80000000;
        msg[47] = 32'h000001c0;

        for (int d = 0; d < NDut; d++) begin
            en[d] = 1'b1; mode[d] = 1'b0; start[d] = 1'b0;
            vld[d] = 1'b0; dat[d] = '0; last[d] = 1'b0;
`ifdef SHA2_MULTI_WIPE_EN
            wipe[d] = 1'b0; wv[d] = '0;
`endif
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_digest0", dg[0], '0);
        chk("rst_digest2", dg[2], '0);
        chk("rst_busy", 256'(busy[0]), 256'(0));
        chk("rst_ready", 256'(rdy[0]), 256'(0));
        chk("rst_done", 256'(done[1]), 256'(0));
        chk("rst_err", 256'(err[2]), 256'(0));

        rst_n = 1'b1;
        @(negedge clk);

        // A word offered in Idle must not be consumed.
        vld[0] = 1'b1;
        dat[0] = 32'hdeadbeef;
        repeat (3) @(negedge clk);
        chk("idle_ready", 256'(rdy[0]), 256'(0));
        chk("idle_busy", 256'(busy[0]), 256'(0));
        vld[0] = 1'b0;

        // SHA-256 "abc", R=1.
        push_exp(Abc256, 66);
        start_msg(0, 1'b0);
        chk("start_busy", 256'(busy[0]), 256'(1));
        chk("start_noerr", 256'(err[0]), 256'(0));
        send_block(0, 0, 1'b1, 0, 1'b0);
        wait_done(0, "abc256_r1");

        // SHA-224 "abc", R=2.
        push_exp(Abc224, 34);
        start_msg(1, 1'b1);
        chk("iv224", dg[1], Iv224);
        send_block(1, 0, 1'b1, 0, 1'b0);
        wait_done(1, "abc224_r2");

        // Two-block message, R=4, random gaps, stray last flags on block 1.
        push_exp(TwoBlk, 18);
        start_msg(2, 1'b0);
        send_block(2, 16, 1'b0, 3, 1'b1);
        send_block(2, 32, 1'b1, 3, 1'b0);
        wait_done(2, "two_r4");

        // hash_start while compressing is rejected with an error pulse.
        push_exp(Abc256, 66);
        start_msg(0, 1'b0);
        send_block(0, 0, 1'b1, 0, 1'b0);
        repeat (10) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        chk("busy_start_err", 256'(err[0]), 256'(1));
        chk("busy_start_busy", 256'(busy[0]), 256'(1));
        @(negedge clk);
        chk("busy_start_errpulse", 256'(err[0]), 256'(0));
        wait_done(0, "abc256_midstart");

        // Drop the enable at round 20, then restart.
        start_msg(0, 1'b0);
        send_block(0, 0, 1'b1, 0, 1'b0);
        repeat (20) @(negedge clk);
        chk("abort_busy_before", 256'(busy[0]), 256'(1));
        en[0] = 1'b0;
        @(negedge clk);
        en[0] = 1'b1;
        chk("abort_busy", 256'(busy[0]), 256'(0));
        chk("abort_digest", dg[0], '0);
        seen_done = done[0];
        repeat (80) begin
            @(negedge clk);
            seen_done = seen_done | done[0];
        end
        chk("abort_nodone", 256'(seen_done), 256'(0));
        push_exp(Abc256, 66);
        start_msg(0, 1'b0);
        send_block(0, 0, 1'b1, 0, 1'b0);
        wait_done(0, "abc256_restart");

`ifdef SHA2_MULTI_WIPE_EN
        wipe[0] = 1'b1;
        wv[0]   = 32'hffffffff;
        @(negedge clk);
        wipe[0] = 1'b0;
        chk("wipe_digest", dg[0], ~Abc256);
        chk("wipe_busy", 256'(busy[0]), 256'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
